// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state encoding and requester source codes for the memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D
    } arb_state_t;

    localparam logic SRC_IF = 1'b0;
    localparam logic SRC_DM = 1'b1;

endpackage

// File: rtl/mem_arb_timer.sv
// mem_arb_timer: per-access timeout counter with clear/enable and a same-cycle expire flag
module mem_arb_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    // expire fires in the TIMEOUT-th counted cycle, so the access is cut before cnt can wrap
    assign expire = en & (cnt == LAST);

    // count waiting cycles of the current access; held at zero while no access is running
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates one single-ported memory between fetch (IF) and load/store (dm) with
// starvation guard and access timeout; define MEM_ARB_PERF_EN to get the stall-cycle counters
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 16,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              bus_err,
    output logic              err_src,
    output logic [31:0]       perf_if_wait,
    output logic [31:0]       perf_dm_wait
);

    import mem_arb_pkg::*;

    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIM);

    arb_state_t    state;
    logic [SW-1:0] starve_cnt;
    logic          busy;
    logic          starved;
    logic          grant_dm;
    logic          expire;
    logic          done;

    assign busy      = state != IDLE;
    assign starved   = starve_cnt == STARVE_MAX;
    assign grant_dm  = dm_req & ~(if_req & starved);
    assign done      = mem_ack | expire;
    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = dm_req & ~dm_ack;

    mem_arb_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (~busy),
        .en    (busy & ~mem_ack),
        .expire(expire)
    );

    // grant in IDLE, hold the memory request while busy, then finish on ack or timeout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            if_ack     <= 1'b0;
            dm_ack     <= 1'b0;
            bus_err    <= 1'b0;
            err_src    <= SRC_IF;
        end else begin
            if_ack  <= 1'b0;
            dm_ack  <= 1'b0;
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_dm) begin
                        state     <= BUSY_D;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
                        if (if_req && !starved)
                            starve_cnt <= starve_cnt + SW'(1);
                    end else if (if_req) begin
                        state      <= BUSY_I;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= if_addr;
                        mem_wdata  <= '0;
                        starve_cnt <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (done) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        if (state == BUSY_D) begin
                            dm_ack   <= 1'b1;
                            dm_rdata <= mem_ack ? mem_rdata : '0;
                        end else begin
                            if_ack   <= 1'b1;
                            if_rdata <= mem_ack ? mem_rdata : '0;
                        end
                        if (!mem_ack) begin
                            bus_err <= 1'b1;
                            err_src <= (state == BUSY_D) ? SRC_DM : SRC_IF;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    // saturating stall-cycle counters for each requester
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_if_wait <= '0;
            perf_dm_wait <= '0;
        end else begin
            if (stall_if && perf_if_wait != 32'hFFFF_FFFF)
                perf_if_wait <= perf_if_wait + 32'd1;
            if (stall_mem && perf_dm_wait != 32'hFFFF_FFFF)
                perf_dm_wait <= perf_dm_wait + 32'd1;
        end
    end
`else
    assign perf_if_wait = '0;
    assign perf_dm_wait = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench with a latency-by-address memory model and arbitration reference
module tb_mem_arbiter;

    localparam int TO = 16;
    localparam int SL = 4;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic        chk;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_ack;
    logic        stall_if;
    logic        stall_mem;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack = 1'b0;
    logic        bus_err;
    logic        err_src;
    logic [31:0] perf_if_wait;
    logic [31:0] perf_dm_wait;

    int total = 0;
    int bad = 0;
    exp_t if_q[$];
    exp_t dm_q[$];

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .STARVE_LIM(SL)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .stall_if(stall_if), .stall_mem(stall_mem),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .bus_err(bus_err), .err_src(err_src),
        .perf_if_wait(perf_if_wait), .perf_dm_wait(perf_dm_wait)
    );

    // memory latency in busy cycles; beyond TO the memory never answers
    function automatic int lat_of(logic [31:0] a);
        if (a == 32'h40) return 3;
        return int'(a[6:2]) % 20 + 1;
    endfunction

    function automatic logic [31:0] data_of(logic [31:0] a);
        if (a == 32'h40) return 32'h2402_0005;
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic exp_t expect_for(logic [31:0] a, logic we);
        exp_t e;
        e.err  = lat_of(a) > TO;
        e.data = e.err ? 32'h0 : data_of(a);
        e.chk  = e.err | ~we;
        return e;
    endfunction

    assign mem_rdata = data_of(mem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // memory model plus arbitration reference: who should win each grant, and when to ack
    logic        prev_req = 1'b0;
    logic        p_if = 1'b0, p_dm = 1'b0, p_we = 1'b0;
    logic [31:0] p_if_addr = '0, p_dm_addr = '0, p_wdata = '0, a_cur = '0;
    logic        win_dm;
    int          starve = 0, k = 0, lat = 0, grants = 0, if_grant_at = -1;

    always @(negedge clk) begin
        if (!rst) begin
            starve   = 0;
            prev_req = 1'b0;
            mem_ack  = 1'b0;
        end else begin
            if (mem_req) begin
                if (!prev_req) begin
                    win_dm = p_dm && !(p_if && starve == SL);
                    if (!p_if && !p_dm) begin
                        total++; bad++;
                        $display("FAIL grant_without_req: addr %h", mem_addr);
                    end else if (win_dm) begin
                        check("grant_dm_addr", mem_addr, p_dm_addr);
                        check("grant_dm_we", mem_we, p_we);
                        if (p_we) check("grant_dm_wdata", mem_wdata, p_wdata);
                        if (p_if && starve < SL) starve++;
                    end else begin
                        check("grant_if_addr", mem_addr, p_if_addr);
                        check("grant_if_we", mem_we, 0);
                        starve = 0;
                        if_grant_at = grants;
                    end
                    grants++;
                    k = 1;
                    a_cur = mem_addr;
                    lat = lat_of(mem_addr);
                end else begin
                    k++;
                    check("mem_addr_stable", mem_addr, a_cur);
                end
                mem_ack = (k == lat);
            end else begin
                mem_ack = ($urandom_range(7) == 0);
            end
            prev_req = mem_req;
        end
        p_if = if_req; p_dm = dm_req; p_we = dm_we;
        p_if_addr = if_addr; p_dm_addr = dm_addr; p_wdata = dm_wdata;
    end

    // scoreboard monitor: pops the expected response whenever a requester is acked
    exp_t e_if, e_dm;
    int   n_if = 0, n_dm = 0;

    always @(negedge clk) begin
        if (!rst) begin
            n_if = 0;
            n_dm = 0;
        end else begin
            check("stall_if", stall_if, if_req & ~if_ack);
            check("stall_mem", stall_mem, dm_req & ~dm_ack);
            if (stall_if) n_if++;
            if (stall_mem) n_dm++;
            if (if_ack) begin
                if (if_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL if_ack_unexpected: rdata %h", if_rdata);
                end else begin
                    e_if = if_q.pop_front();
                    if (e_if.chk) check("if_rdata", if_rdata, e_if.data);
                    check("if_bus_err", bus_err, e_if.err);
                    if (e_if.err) check("if_err_src", err_src, 0);
                end
            end
            if (dm_ack) begin
                if (dm_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL dm_ack_unexpected: rdata %h", dm_rdata);
                end else begin
                    e_dm = dm_q.pop_front();
                    if (e_dm.chk) check("dm_rdata", dm_rdata, e_dm.data);
                    check("dm_bus_err", bus_err, e_dm.err);
                    if (e_dm.err) check("dm_err_src", err_src, 1);
                end
            end
            if (!if_ack && !dm_ack) check("bus_err_quiet", bus_err, 0);
        end
    end

    task automatic wait_if_ack();
        int c = 0;
        do begin
            @(posedge clk); #1; c++;
        end while (!if_ack && c < 200);
        if (!if_ack) begin
            total++; bad++;
            $display("FAIL if_ack_wait: no ack after %0d cycles, want ack", c);
        end
    endtask

    task automatic wait_dm_ack();
        int c = 0;
        do begin
            @(posedge clk); #1; c++;
        end while (!dm_ack && c < 200);
        if (!dm_ack) begin
            total++; bad++;
            $display("FAIL dm_ack_wait: no ack after %0d cycles, want ack", c);
        end
    endtask

    // one fetch; gap 0 keeps req high straight through the previous ack cycle
    task automatic if_txn(input logic [31:0] a, input int gap);
        if (gap > 0) begin
            if_req = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
        if_addr = a;
        if_q.push_back(expect_for(a, 1'b0));
        if_req = 1'b1;
        wait_if_ack();
    endtask

    task automatic dm_txn(input logic [31:0] a, input logic we, input logic [31:0] wd, input int gap);
        if (gap > 0) begin
            dm_req = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
        dm_addr  = a;
        dm_we    = we;
        dm_wdata = wd;
        dm_q.push_back(expect_for(a, we));
        dm_req = 1'b1;
        wait_dm_ack();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    initial begin
        int base;
        int c;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_if_ack", if_ack, 0);
        check("rst_dm_ack", dm_ack, 0);
        check("rst_bus_err", bus_err, 0);
        check("rst_err_src", err_src, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_dm_rdata", dm_rdata, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        if_txn(32'h40, 1);
        if_req = 1'b0;
        check("lone_if_rdata", if_rdata, 32'h2402_0005);

        base = grants;
        fork
            begin if_txn(32'h84, 2); if_req = 1'b0; end
            begin dm_txn(32'h100, 1'b1, 32'hDEAD_BEEF, 2); dm_req = 1'b0; end
        join
        check("both_if_second", if_grant_at - base, 1);

        base = grants;
        fork
            begin if_txn(32'h88, 2); if_req = 1'b0; end
            begin
                for (int i = 0; i < 6; i++)
                    dm_txn(32'h200 + 32'(i * 4), 1'b0, 32'h0, (i == 0) ? 2 : 0);
                dm_req = 1'b0;
            end
        join
        check("starve_if_5th", if_grant_at - base, SL);

        dm_txn(32'h4C, 1'b0, 32'h0, 2);
        dm_req = 1'b0;
        check("timeout_dm_rdata", dm_rdata, 0);
        check("timeout_err_src", err_src, 1);
        dm_txn(32'h3C, 1'b0, 32'h0, 2);
        dm_req = 1'b0;
        check("ack_at_timeout_bus_err", bus_err, 0);
        check("err_src_holds", err_src, 1);

        fork
            begin
                for (int i = 0; i < 40; i++)
                    if_txn($urandom & 32'hFFFF_FFFC, $urandom_range(3));
                if_req = 1'b0;
            end
            begin
                for (int i = 0; i < 40; i++)
                    dm_txn($urandom & 32'hFFFF_FFFC, 1'(($urandom_range(1))), $urandom, $urandom_range(3));
                dm_req = 1'b0;
            end
        join

        repeat (2) @(posedge clk); #1;
        if_addr = 32'h40;
        if_q.push_back(expect_for(32'h40, 1'b0));
        if_req = 1'b1;
        c = 0;
        do begin @(posedge clk); #1; c++; end while (!mem_req && c < 50);
        check("rst_test_granted", mem_req, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("mid_rst_mem_req", mem_req, 0);
        check("mid_rst_if_ack", if_ack, 0);
        repeat (3) @(posedge clk); #1;
        rst = 1'b1;
        base = grants;
        wait_if_ack();
        if_req = 1'b0;
        check("regrant_after_rst", if_grant_at - base, 0);
        check("regrant_rdata", if_rdata, 32'h2402_0005);

        repeat (4) @(posedge clk); #1;
        check("if_q_drained", if_q.size(), 0);
        check("dm_q_drained", dm_q.size(), 0);
`ifdef MEM_ARB_PERF_EN
        check("perf_if_wait", perf_if_wait, 32'(n_if));
        check("perf_dm_wait", perf_dm_wait, 32'(n_dm));
`else
        check("perf_if_wait", perf_if_wait, 0);
        check("perf_dm_wait", perf_dm_wait, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
